// File: rtl/tile2048_pkg.sv
// rtl/tile2048_pkg.sv - shared board geometry defaults and slice helper
// Purpose: default 2048 board geometry, tile value code width, empty code,
//          and the row-major slice helper used to unpack the board vector.
// Ports:   none (package).
package tile2048_pkg;

  localparam int GRID_DEF   = 4;
  localparam int TILE_DEF   = 80;
  localparam int GAP_DEF    = 16;
  localparam int X0_DEF     = 136;
  localparam int Y0_DEF     = 66;
  localparam int TILE_VAL_W = 4;

  localparam logic [TILE_VAL_W-1:0] EMPTY = '0;

  // MSB position of tile idx in a row-major board vector with tile 0 in
  // the most significant slice.
  function automatic int tile_slice(input int idx, input int grid, input int val_w);
    return (grid * grid - idx) * val_w - 1;
  endfunction

endpackage

// File: rtl/axis_locator.sv
// rtl/axis_locator.sv - one-axis tile range compare
// Purpose: finds which of GRID tiles along one axis contains i_cnt, using
//          GRID parallel half-open range compares (no divider).
// Ports:   i_cnt  raster count on this axis
//          o_hit  i_cnt lies inside a tile (not in a gap or margin)
//          o_idx  tile column/row index (0 when no hit)
//          o_off  pixel offset inside the tile (0 when no hit)
module axis_locator #(
  parameter int GRID   = 4,
  parameter int TILE   = 80,
  parameter int GAP    = 16,
  parameter int ORIGIN = 136,
  parameter int CNT_W  = 11,
  parameter int IDX_W  = 2,
  parameter int OFF_W  = 7
) (
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx,
  output logic [OFF_W-1:0] o_off
);

  localparam int PITCH = TILE + GAP;

  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    o_off = '0;
    // Ranges are disjoint, so at most one compare fires.
    for (int c = 0; c < GRID; c++) begin
      if ((int'(i_cnt) >= ORIGIN + c * PITCH) &&
          (int'(i_cnt) <  ORIGIN + c * PITCH + TILE)) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(c);
        o_off = OFF_W'(int'(i_cnt) - (ORIGIN + c * PITCH));
      end
    end
  end

endmodule

// File: rtl/tile_locator_pipe.sv
// rtl/tile_locator_pipe.sv - two-stage raster to tile locator with frame snapshot
// Purpose: maps (h_cnt, v_cnt) to a tile of a GRID x GRID board, returning
//          tile index, value code, in-tile offsets and a spawn flash flag,
//          all from a board snapshot taken once per frame at raster (0,0).
// Ports:   clk, rst_n          pixel clock, async active-low reset
//          h_cnt, v_cnt        raster position, one per cycle
//          data                live board, tile 0 in the MS slice, row-major
//          curpos              tile index+1, 0 for background
//          curdata             tile value code from the snapshot
//          off_x, off_y        pixel offsets inside the tile
//          flash               tile spawned within the last FLASH_FRAMES frames
//          frame_start         pulse aligned with the outputs of raster (0,0)
module tile_locator_pipe
  import tile2048_pkg::*;
#(
  parameter int GRID         = GRID_DEF,
  parameter int TILE         = TILE_DEF,
  parameter int GAP          = GAP_DEF,
  parameter int X0           = X0_DEF,
  parameter int Y0           = Y0_DEF,
  parameter int CNT_W        = 11,
  parameter int VAL_W        = TILE_VAL_W,
  parameter int FLASH_FRAMES = 8,
  localparam int POS_W       = $clog2(GRID * GRID + 1),
  localparam int OFF_W       = $clog2(TILE),
  localparam int FL_W        = $clog2(FLASH_FRAMES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CNT_W-1:0]            h_cnt,
  input  logic [CNT_W-1:0]            v_cnt,
  input  logic [GRID*GRID*VAL_W-1:0]  data,
  output logic [POS_W-1:0]            curpos,
  output logic [VAL_W-1:0]            curdata,
  output logic [OFF_W-1:0]            off_x,
  output logic [OFF_W-1:0]            off_y,
  output logic                        flash,
  output logic                        frame_start
);

  localparam int NT    = GRID * GRID;
  localparam int IDX_W = (GRID > 1) ? $clog2(GRID) : 1;

  logic             w_hit_x, w_hit_y;
  logic [IDX_W-1:0] w_col, w_row;
  logic [OFF_W-1:0] w_off_x, w_off_y;
  logic             w_fs0;

  logic             r_hit_x, r_hit_y, r_fs1;
  logic [IDX_W-1:0] r_col, r_row;
  logic [OFF_W-1:0] r_off_x, r_off_y;

  logic [NT*VAL_W-1:0] r_snap;
  logic [FL_W-1:0]     r_fl [NT];
  logic [VAL_W-1:0]    w_new [NT];
  logic [VAL_W-1:0]    w_old [NT];

  int               w_idx;
  logic [VAL_W-1:0] w_sel_val;
  logic             w_sel_fl;

  assign w_fs0 = (h_cnt == '0) && (v_cnt == '0);

  axis_locator #(
    .GRID(GRID), .TILE(TILE), .GAP(GAP), .ORIGIN(X0),
    .CNT_W(CNT_W), .IDX_W(IDX_W), .OFF_W(OFF_W)
  ) u_loc_x (
    .i_cnt(h_cnt), .o_hit(w_hit_x), .o_idx(w_col), .o_off(w_off_x)
  );

  axis_locator #(
    .GRID(GRID), .TILE(TILE), .GAP(GAP), .ORIGIN(Y0),
    .CNT_W(CNT_W), .IDX_W(IDX_W), .OFF_W(OFF_W)
  ) u_loc_y (
    .i_cnt(v_cnt), .o_hit(w_hit_y), .o_idx(w_row), .o_off(w_off_y)
  );

  // Stage 1: per-axis locate results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_x <= 1'b0;
      r_hit_y <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_off_x <= '0;
      r_off_y <= '0;
      r_fs1   <= 1'b0;
    end else begin
      r_hit_x <= w_hit_x;
      r_hit_y <= w_hit_y;
      r_col   <= w_col;
      r_row   <= w_row;
      r_off_x <= w_off_x;
      r_off_y <= w_off_y;
      r_fs1   <= w_fs0;
    end
  end

  for (genvar k = 0; k < NT; k++) begin : g_unpack
    assign w_new[k] = data[tile_slice(k, GRID, VAL_W) -: VAL_W];
    assign w_old[k] = r_snap[tile_slice(k, GRID, VAL_W) -: VAL_W];
  end

  // Snapshot and flash counters advance together at raster (0,0); the
  // stage-2 lookup of (0,0) lands one cycle later and sees the new board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
      for (int k = 0; k < NT; k++) r_fl[k] <= '0;
    end else if (w_fs0) begin
      r_snap <= data;
      for (int k = 0; k < NT; k++) begin
        if (w_old[k] == VAL_W'(EMPTY) && w_new[k] != VAL_W'(EMPTY))
          r_fl[k] <= FL_W'(FLASH_FRAMES);
        else if (w_new[k] == VAL_W'(EMPTY))
          r_fl[k] <= '0;
        else if (r_fl[k] != '0)
          r_fl[k] <= r_fl[k] - FL_W'(1);
      end
    end
  end

  always_comb begin
    w_idx     = int'(r_row) * GRID + int'(r_col);
    w_sel_val = '0;
    w_sel_fl  = 1'b0;
    for (int k = 0; k < NT; k++) begin
      if (k == w_idx) begin
        w_sel_val = w_old[k];
        w_sel_fl  = (r_fl[k] != '0);
      end
    end
  end

  // Stage 2: tile lookup, background forces everything to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curpos      <= '0;
      curdata     <= '0;
      off_x       <= '0;
      off_y       <= '0;
      flash       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= r_fs1;
      if (r_hit_x && r_hit_y) begin
        curpos  <= POS_W'(w_idx + 1);
        curdata <= w_sel_val;
        off_x   <= r_off_x;
        off_y   <= r_off_y;
        flash   <= w_sel_fl;
      end else begin
        curpos  <= '0;
        curdata <= '0;
        off_x   <= '0;
        off_y   <= '0;
        flash   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tile_locator_pipe.sv
// tb/tb_tile_locator_pipe.sv - directed self-checking bench for tile_locator_pipe
module tb_tile_locator_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] h, v, h2, v2;
  logic [63:0] data;
  logic [99:0] data2;

  logic [4:0] curpos;
  logic [3:0] curdata;
  logic [6:0] off_x, off_y;
  logic       flash, fs;

  logic [4:0] curpos2;
  logic [3:0] curdata2;
  logic [5:0] off_x2, off_y2;
  logic       flash2, fs2;

  int n_checks = 0;
  int n_errors = 0;
  int cnt2 [26];
  int n_fs2;
  int n_samp;

  always #5 clk = ~clk;

  tile_locator_pipe dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h), .v_cnt(v), .data(data),
    .curpos(curpos), .curdata(curdata), .off_x(off_x), .off_y(off_y),
    .flash(flash), .frame_start(fs)
  );

  tile_locator_pipe #(
    .GRID(5), .TILE(60), .GAP(8), .X0(2), .Y0(2)
  ) dut5 (
    .clk(clk), .rst_n(rst_n), .h_cnt(h2), .v_cnt(v2), .data(data2),
    .curpos(curpos2), .curdata(curdata2), .off_x(off_x2), .off_y(off_y2),
    .flash(flash2), .frame_start(fs2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_tile(input int idx, input logic [3:0] val);
    data[(15 - idx) * 4 +: 4] = val;
  endtask

  task automatic look(input int hh, input int vv);
    @(negedge clk);
    h = 11'(hh);
    v = 11'(vv);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic new_frame();
    @(negedge clk);
    h = 11'd0;
    v = 11'd0;
    @(negedge clk);
    h = 11'd1;
    v = 11'd1;
    @(negedge clk);
    check_val("frame_start", fs, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    h = 11'd1; v = 11'd1; h2 = 11'd1; v2 = 11'd1;
    data = '0; data2 = '0;
    repeat (3) @(negedge clk);
    check_val("rst curpos", curpos, 0);
    check_val("rst curdata", curdata, 0);
    check_val("rst flash", flash, 0);
    check_val("rst frame_start", fs, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: two cycles from input to output.
    @(negedge clk); h = 11'd136; v = 11'd66;
    @(negedge clk); check_val("lat 1 cycle", curpos, 0);
    @(negedge clk); check_val("lat 2 cycles", curpos, 1);
    check_val("lat off_x", off_x, 0);

    look(215, 66);  check_val("col0 right curpos", curpos, 1); check_val("col0 right off_x", off_x, 79);
    look(216, 66);  check_val("gap curpos", curpos, 0);        check_val("gap off_x", off_x, 0);
    look(135, 66);  check_val("left margin", curpos, 0);
    look(136, 65);  check_val("top margin", curpos, 0);
    look(504, 433); check_val("right edge", curpos, 0);
    look(503, 434); check_val("bottom edge", curpos, 0);

    // Tile 15 in the far corner.
    set_tile(15, 4'h3);
    new_frame();
    check_val("fs one cycle", curpos, 0);
    @(negedge clk); check_val("fs drops", fs, 0);
    look(503, 433);
    check_val("t15 curpos", curpos, 16);
    check_val("t15 curdata", curdata, 3);
    check_val("t15 off_x", off_x, 79);
    check_val("t15 off_y", off_y, 79);
    check_val("t15 flash", flash, 1);
    look(312, 100);
    check_val("gap2 curpos", curpos, 0);
    check_val("gap2 curdata", curdata, 0);
    check_val("gap2 flash", flash, 0);

    // Snapshot: mid-frame data changes are held off until the next (0,0).
    set_tile(5, 4'h7);
    new_frame();
    look(240, 170);
    check_val("t5 curpos", curpos, 6);
    check_val("t5 curdata", curdata, 7);
    check_val("t5 off_x", off_x, 8);
    check_val("t5 off_y", off_y, 8);
    set_tile(5, 4'h9);
    look(240, 170);
    check_val("t5 same frame", curdata, 7);
    new_frame();
    look(240, 170);
    check_val("t5 next frame", curdata, 9);

    // Tile 6 spawn flash for exactly eight frames; a merge does not re-flash.
    set_tile(6, 4'h2);
    new_frame();
    look(330, 170);
    check_val("t6 curpos", curpos, 7);
    check_val("t6 curdata", curdata, 2);
    check_val("t6 flash f0", flash, 1);
    for (int f = 1; f < 8; f++) begin
      if (f == 3) set_tile(6, 4'h3);
      new_frame();
      look(330, 170);
      check_val($sformatf("t6 flash f%0d", f), flash, 1);
    end
    check_val("t6 merged curdata", curdata, 3);
    new_frame();
    look(330, 170);
    check_val("t6 flash f8", flash, 0);
    new_frame();
    look(330, 170);
    check_val("t6 flash f9", flash, 0);
    look(503, 433);
    check_val("t15 flash expired", flash, 0);

    // Asynchronous reset in the middle of a line.
    look(503, 433);
    check_val("pre-rst curpos", curpos, 16);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("async rst curpos", curpos, 0);
    check_val("async rst curdata", curdata, 0);
    check_val("async rst off_x", off_x, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    look(232, 162);
    check_val("post-rst curpos", curpos, 6);
    check_val("post-rst curdata", curdata, 0);
    check_val("post-rst flash", flash, 0);
    new_frame();
    look(232, 162);
    check_val("reflash t5 curdata", curdata, 9);
    check_val("reflash t5 flash", flash, 1);
    look(503, 433);
    check_val("reflash t15 flash", flash, 1);
    look(330, 170);
    check_val("reflash t6 flash", flash, 1);
    look(136, 66);
    check_val("empty t0 flash", flash, 0);

    // GRID=5 sweep over the first two tile rows.
    for (int k = 0; k < 26; k++) cnt2[k] = 0;
    n_fs2  = 0;
    n_samp = 0;
    for (int vv = 0; vv < 135; vv++) begin
      for (int hh = 0; hh < 340; hh++) begin
        @(negedge clk);
        cnt2[curpos2]++;
        if (fs2) n_fs2++;
        n_samp++;
        h2 = 11'(hh);
        v2 = 11'(vv);
      end
    end
    repeat (2) begin
      @(negedge clk);
      cnt2[curpos2]++;
      if (fs2) n_fs2++;
      n_samp++;
      h2 = 11'd1;
      v2 = 11'd1;
    end
    for (int k = 1; k < 26; k++)
      check_val($sformatf("g5 count k=%0d", k), cnt2[k], (k <= 10) ? 3600 : 0);
    check_val("g5 background count", cnt2[0], n_samp - 36000);
    check_val("g5 frame_start pulses", n_fs2, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_locator_pipe.md
Name: tile_locator_pipe

Overview:
- Parametrised, pipelined successor to the board position checker in the 2048 VGA path.
- Maps the raster position (h_cnt, v_cnt) to a tile on a GRID x GRID board; returns the tile index, its value code and the pixel offsets inside the tile.
- Snapshots the board once per frame so a whole frame renders from one consistent board (no tearing).
- Flags newly spawned tiles for FLASH_FRAMES frames. Sits between the game-state register and the tile/number pixel generator.

Parameters:
- GRID, 4, tiles per row and per column.
- TILE, 80, tile edge length in pixels.
- GAP, 16, pixel gap between adjacent tiles.
- X0, 136, h_cnt of the left edge of column 0.
- Y0, 66, v_cnt of the top edge of row 0.
- CNT_W, 11, width of h_cnt and v_cnt.
- VAL_W, 4, bits per tile value code.
- FLASH_FRAMES, 8, number of frames a new tile is flagged; must be at least 1.
- Derived localparams: POS_W = clog2(GRID*GRID+1), OFF_W = clog2(TILE), FL_W = clog2(FLASH_FRAMES+1).

Ports:
- clk  in  1  pixel clock; one raster position per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- h_cnt  in  CNT_W  horizontal raster count.
- v_cnt  in  CNT_W  vertical raster count.
- data  in  GRID*GRID*VAL_W  live board; tile 0 (row 0, col 0) in the MS slice, row-major.
- curpos  out  POS_W  1..GRID*GRID = tile index+1; 0 = background.
- curdata  out  VAL_W  value code of the tile under the pixel; 0 when curpos=0.
- off_x  out  OFF_W  pixel column inside the tile; 0 when curpos=0.
- off_y  out  OFF_W  pixel row inside the tile; 0 when curpos=0.
- flash  out  1  the tile under the pixel is newly spawned; 0 when curpos=0.
- frame_start  out  1  one-cycle pulse, aligned with the outputs, for raster (0,0).

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, pipeline registers 0, board snapshot 0, all flash counters 0.
- Geometry: pitch P = TILE+GAP.
  - Column c is hit when X0 + c*P <= h_cnt < X0 + c*P + TILE. Rows use Y0 and v_cnt the same way.
  - Pixels in a gap, left of X0, above Y0, or beyond the last tile are background. This includes the right/bottom edge at exactly X0+GRID*P-GAP.
  - Edges are uniformly half-open. The old one-pixel-wider first tile is not reproduced.
- Stage 1 (registered):
  - Column and row are found by GRID parallel range compares. No divider.
  - Register hit_x, col, off_x = h_cnt - (X0+col*P), and the same for y.
  - Register fs1 = (h_cnt==0 && v_cnt==0).
- Stage 2 (registered):
  - idx = row*GRID + col.
  - When hit_x && hit_y: curpos = idx+1, curdata = snapshot slice idx, flash = (flash_cnt[idx] != 0), offsets forwarded.
  - Otherwise curpos, curdata, off_x, off_y and flash are all 0.
  - frame_start = fs1.
- Latency: exactly 2 clk cycles from h_cnt/v_cnt to all outputs. Throughput 1 pixel per cycle.
- Snapshot: on the cycle where h_cnt==0 && v_cnt==0 is sampled, data is latched into the board snapshot.
  - Stage 2 reads the snapshot only, so changes to data mid-frame are invisible until the next frame.
  - The stage-2 lookup for raster (0,0) itself happens after the latch and therefore uses the new snapshot.
- Flash counters: one FL_W counter per tile, updated on the same snapshot cycle, per tile:
  - old snapshot code == 0 and new data code != 0: load FLASH_FRAMES.
  - else if new code == 0: clear to 0.
  - else if counter != 0: decrement by 1.
  - Load takes priority over decrement.
  - Net effect: flash is visible for exactly FLASH_FRAMES frames, counting the spawn frame.
- Simultaneous events: a tile value changing non-zero to non-zero (a merge) does not trigger flash; its counter keeps decrementing.
- Reset mid-frame: outputs drop to 0 immediately. After release, the snapshot stays 0 (all background codes) until the next (0,0). The first snapshot after reset flags every non-zero tile.
- Counts greater than or equal to 2^CNT_W cannot occur. No wrap handling is required beyond unsigned compares.

Decomposition:
- Shared package tile2048_pkg:
  - GRID, TILE, GAP, X0, Y0 defaults.
  - VAL_W and the EMPTY = 0 value code.
  - Helper function tile_slice(idx) returning the MSB position for row-major unpacking.
- One sub-module, axis_locator: the GRID-way range compare for one axis, returning hit, index and offset. It is instantiated twice, for x and y.

Test Plan:
- Default params, raster (136,66) then (215,66) then (216,66) -> 2 cycles later curpos = 1, 1, 0; off_x = 0, 79, 0.
- Board with tile 15 = 4'h3; raster (503,433) -> curpos = 16, curdata = 3, off_x = off_y = 79. Raster (312,100) (gap) -> curpos = 0, curdata = 0.
- Change data mid-frame, then sample tile 5 on the same frame and the next frame -> old value until the next (0,0); new value after it.
- Tile 6 goes 0 -> 2 before frame N -> flash = 1 in frames N..N+7 and 0 in frame N+8. Tile 6 then changes 2 -> 3 -> no re-flash.
- Assert rst_n=0 for 3 cycles mid-line -> all outputs 0 asynchronously. Tile at (232,162) reads curdata = 0 until the next (0,0); then all non-zero tiles flash.
- GRID=5, TILE=60, GAP=8 override, sweep a full frame -> count of curpos=k pixels equals 3600 for every k in 1..25; frame_start pulses once per frame.
